// File: rtl/soc_status_pkg.sv
// Shared types and constants for the line-scanner status snapshot block.
package soc_status_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } snap_state_e;

    localparam logic [2:0] ADDR_SNAP    = 3'd0;
    localparam logic [2:0] ADDR_LIVE    = 3'd1;
    localparam logic [2:0] ADDR_CTRL    = 3'd2;
    localparam logic [2:0] ADDR_STICKY  = 3'd3;
    localparam logic [2:0] ADDR_MASK    = 3'd4;
    localparam logic [2:0] ADDR_SNAPCNT = 3'd5;

    localparam int CTRL_SNAP_REQ_BIT = 0;
    localparam int CTRL_RELEASE_BIT  = 1;
    localparam int CTRL_DONE_BIT     = 2;
    localparam int CTRL_TIMEOUT_BIT  = 3;

endpackage

// File: rtl/soc_status_sync.sv
// Multi-bit flop-chain synchroniser for quasi-static status bits.
module soc_status_sync #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    // Shift the asynchronous input through STAGES flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/soc_status_snapshot_ctrl.sv
// Status snapshot controller: synchronises scanner status, freezes a debounced
// snapshot on request, and collects sticky events with mask and interrupt.
module soc_status_snapshot_ctrl
    import soc_status_pkg::*;
#(
    parameter int STATUS_W    = 32,
    parameter int EVT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [STATUS_W-1:0] status_async,
    input  logic [EVT_W-1:0]    evt_pulse,
    input  logic [2:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic [31:0]         pio_in_port,
    output logic                irq
);

    localparam int SC_W = $clog2(STABLE_CYC + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SC_W-1:0] STABLE_MAX = SC_W'(STABLE_CYC);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

    logic [STATUS_W-1:0] live, live_d, snap_reg;
    snap_state_e         state_q, state_d;
    logic [SC_W-1:0]     stable_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                done_q, timeout_q;
    logic [15:0]         snap_cnt;
    logic [31:0]         sticky, mask, sticky_set, sticky_clr, rd_mux;
    logic                ctrl_wr, snap_req, rel_req;
    logic                start_cap, enter_hold, hit_timeout;

    soc_status_sync #(.W(STATUS_W), .STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (status_async),
        .q       (live)
    );

    assign ctrl_wr    = avs_write && (avs_address == ADDR_CTRL);
    assign snap_req   = ctrl_wr && avs_writedata[CTRL_SNAP_REQ_BIT];
    assign rel_req    = ctrl_wr && avs_writedata[CTRL_RELEASE_BIT];
    assign sticky_clr = (avs_write && (avs_address == ADDR_STICKY)) ? avs_writedata : 32'd0;

    // Capture completion lands in the sticky bit just above the event inputs
    if (EVT_W < 32) begin : g_done_evt
        assign sticky_set = 32'(evt_pulse) | (32'(enter_hold) << EVT_W);
    end else begin : g_no_done_evt
        assign sticky_set = 32'(evt_pulse);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state; RELEASE outranks SNAP_REQ and capture completion
    always_comb begin
        state_d     = state_q;
        start_cap   = 1'b0;
        enter_hold  = 1'b0;
        hit_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_req && !rel_req) begin
                    state_d   = CAPTURE;
                    start_cap = 1'b1;
                end
            end
            CAPTURE: begin
                if (rel_req) begin
                    state_d = IDLE;
                end else if (stable_cnt == STABLE_MAX) begin
                    state_d    = HOLD;
                    enter_hold = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    state_d     = HOLD;
                    enter_hold  = 1'b1;
                    hit_timeout = 1'b1;
                end
            end
            HOLD: begin
                if (rel_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot tracking, stability/timeout counters and capture status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_d     <= '0;
            snap_reg   <= '0;
            stable_cnt <= '0;
            to_cnt     <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            snap_cnt   <= '0;
        end else begin
            live_d <= live;
            if (state_q != HOLD) snap_reg <= live;
            if (start_cap) begin
                stable_cnt <= '0;
                to_cnt     <= '0;
                done_q     <= 1'b0;
                timeout_q  <= 1'b0;
            end else if (state_q == CAPTURE) begin
                if (live == live_d) begin
                    if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + SC_W'(1);
                end else begin
                    stable_cnt <= '0;
                end
                if (to_cnt != TO_LAST) to_cnt <= to_cnt + TO_W'(1);
            end
            if (enter_hold) begin
                done_q    <= 1'b1;
                timeout_q <= hit_timeout;
                snap_cnt  <= snap_cnt + 16'd1;
            end
        end
    end

    // Sticky events (set beats same-cycle clear), mask and registered interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky <= '0;
            mask   <= '0;
            irq    <= 1'b0;
        end else begin
            sticky <= (sticky & ~sticky_clr) | sticky_set;
            if (avs_write && (avs_address == ADDR_MASK)) mask <= avs_writedata;
            irq <= |(sticky & mask);
        end
    end

    // Register read mux
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_SNAP:    rd_mux = 32'(snap_reg);
            ADDR_LIVE:    rd_mux = 32'(live);
            ADDR_CTRL: begin
                rd_mux[1:0]              = state_q;
                rd_mux[CTRL_DONE_BIT]    = done_q;
                rd_mux[CTRL_TIMEOUT_BIT] = timeout_q;
            end
            ADDR_STICKY:  rd_mux = sticky;
            ADDR_MASK:    rd_mux = mask;
            ADDR_SNAPCNT: rd_mux = {16'd0, snap_cnt};
            default:      rd_mux = '0;
        endcase
    end

    // Read data with one cycle of latency, held between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      avs_readdata <= '0;
        else if (avs_read) avs_readdata <= rd_mux;
    end

    assign pio_in_port = 32'(snap_reg);

endmodule

// File: tb/tb_soc_status_snapshot_ctrl.sv
// Bench for soc_status_snapshot_ctrl: register-map vectors, snapshot/timeout/abort
// sequences, sticky/irq corners, async reset, and a randomized sticky/live phase.
`timescale 1ns/1ps
module tb_soc_status_snapshot_ctrl;
    import soc_status_pkg::*;

    localparam int STATUS_W    = 32;
    localparam int EVT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 1024;
    localparam int RAND_CYC    = 400;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [STATUS_W-1:0] status_async = '0;
    logic [EVT_W-1:0]    evt_pulse = '0;
    logic [2:0]          avs_address = '0;
    logic                avs_read = 1'b0;
    logic                avs_write = 1'b0;
    logic [31:0]         avs_writedata = '0;
    logic [31:0]         avs_readdata;
    logic [31:0]         pio_in_port;
    logic                irq;

    int          checks = 0;
    int          errors = 0;
    logic        toggle_en = 1'b0;
    logic [31:0] rd;
    logic [31:0] s_init;
    logic [31:0] hist [RAND_CYC];

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vq[$];

    soc_status_snapshot_ctrl #(
        .STATUS_W(STATUS_W), .EVT_W(EVT_W), .SYNC_STAGES(SYNC_STAGES),
        .STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .status_async(status_async), .evt_pulse(evt_pulse),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .pio_in_port(pio_in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) status_async[0] = ~status_async[0];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    function automatic logic [31:0] hist_at(input int i);
        return (i < 0) ? s_init : hist[i];
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1);
    end

    initial begin
        // ---- reset and register map ----
        repeat (3) @(posedge clk);
        #1;
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_pio", pio_in_port, 32'd0);
        check("reset_readdata", avs_readdata, 32'd0);
        #2 reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) vq.push_back('{1'b0, 3'(i), 32'd0, 32'd0});
        vq.push_back('{1'b1, ADDR_MASK, 32'hDEAD_BEEF, 32'd0});
        vq.push_back('{1'b0, ADDR_MASK, 32'd0, 32'hDEAD_BEEF});
        vq.push_back('{1'b1, 3'd6, 32'hFFFF_FFFF, 32'd0});
        vq.push_back('{1'b0, 3'd6, 32'd0, 32'd0});
        vq.push_back('{1'b1, ADDR_SNAPCNT, 32'h0000_1234, 32'd0});
        vq.push_back('{1'b0, ADDR_SNAPCNT, 32'd0, 32'd0});
        vq.push_back('{1'b1, ADDR_LIVE, 32'h0000_0055, 32'd0});
        vq.push_back('{1'b0, ADDR_LIVE, 32'd0, 32'd0});
        vq.push_back('{1'b1, ADDR_MASK, 32'd0, 32'd0});
        vq.push_back('{1'b0, ADDR_MASK, 32'd0, 32'd0});
        foreach (vq[i]) begin
            if (vq[i].wr) bus_write(vq[i].addr, vq[i].wdata);
            else begin
                bus_read(vq[i].addr, rd);
                check($sformatf("regmap[%0d]", i), rd, vq[i].exp);
            end
        end
        check("idle_irq", 32'(irq), 32'd0);

        // ---- live latency ----
        status_async = 32'h1234_5678;
        repeat (SYNC_STAGES) tick();
        check("pio_not_early", pio_in_port, 32'd0);
        tick();
        check("pio_follows_live", pio_in_port, 32'h1234_5678);
        bus_read(ADDR_LIVE, rd);
        check("live_read", rd, 32'h1234_5678);

        // ---- stable capture ----
        status_async = 32'hA5A5_0001;
        repeat (SYNC_STAGES + 2) tick();
        bus_write(ADDR_CTRL, 32'd1);
        repeat (STABLE_CYC) tick();
        bus_read(ADDR_CTRL, rd);
        check("still_capturing", rd, 32'h1);
        bus_read(ADDR_CTRL, rd);
        check("hold_ctrl", rd, 32'h6);
        bus_read(ADDR_SNAP, rd);
        check("snap_value", rd, 32'hA5A5_0001);
        bus_read(ADDR_SNAPCNT, rd);
        check("snapcnt_1", rd, 32'd1);
        status_async = 32'h0F0F_F0F0;
        repeat (SYNC_STAGES + 2) tick();
        bus_read(ADDR_SNAP, rd);
        check("snap_frozen", rd, 32'hA5A5_0001);
        check("pio_frozen", pio_in_port, 32'hA5A5_0001);
        bus_read(ADDR_LIVE, rd);
        check("live_while_hold", rd, 32'h0F0F_F0F0);
        bus_read(ADDR_STICKY, rd);
        check("done_sticky", rd, 32'h1 << EVT_W);
        bus_write(ADDR_STICKY, 32'hFFFF_FFFF);
        bus_write(ADDR_CTRL, 32'd2);
        bus_read(ADDR_CTRL, rd);
        check("release_idle", rd & 32'h3, 32'h0);

        // ---- timeout capture ----
        toggle_en = 1'b1;
        repeat (4) tick();
        bus_write(ADDR_CTRL, 32'd1);
        repeat (TIMEOUT_CYC - 1) tick();
        bus_read(ADDR_CTRL, rd);
        check("timeout_not_early", rd, 32'h1);
        bus_read(ADDR_CTRL, rd);
        check("timeout_ctrl", rd, 32'hE);
        toggle_en = 1'b0;
        bus_read(ADDR_SNAPCNT, rd);
        check("snapcnt_2", rd, 32'd2);
        bus_write(ADDR_CTRL, 32'd1);
        bus_read(ADDR_CTRL, rd);
        check("snapreq_ignored_hold", rd, 32'hE);
        bus_write(ADDR_CTRL, 32'd2);

        // ---- release priority and abort ----
        repeat (SYNC_STAGES + 2) tick();
        bus_write(ADDR_CTRL, 32'd3);
        bus_read(ADDR_CTRL, rd);
        check("both_bits_idle", rd & 32'h3, 32'h0);
        bus_write(ADDR_CTRL, 32'd1);
        bus_read(ADDR_CTRL, rd);
        check("restart_clears", rd, 32'h1);
        bus_write(ADDR_CTRL, 32'd2);
        bus_read(ADDR_CTRL, rd);
        check("abort_ctrl", rd, 32'h0);
        bus_read(ADDR_SNAPCNT, rd);
        check("abort_snapcnt", rd, 32'd2);

        // ---- sticky, mask, irq ----
        bus_write(ADDR_STICKY, 32'hFFFF_FFFF);
        bus_write(ADDR_MASK, 32'h1);
        check("irq_clear_start", 32'(irq), 32'd0);
        evt_pulse = 8'h01;
        tick();
        evt_pulse = '0;
        check("irq_not_early", 32'(irq), 32'd0);
        tick();
        check("irq_set", 32'(irq), 32'd1);
        evt_pulse = 8'h01;
        bus_write(ADDR_STICKY, 32'h1);
        evt_pulse = '0;
        bus_read(ADDR_STICKY, rd);
        check("set_beats_clear", rd, 32'h1);
        check("irq_still_set", 32'(irq), 32'd1);
        bus_write(ADDR_STICKY, 32'h1);
        check("irq_lag", 32'(irq), 32'd1);
        tick();
        check("irq_cleared", 32'(irq), 32'd0);

        // ---- async reset while holding ----
        status_async = 32'h5555_AAAA;
        repeat (SYNC_STAGES + 2) tick();
        bus_write(ADDR_CTRL, 32'd1);
        repeat (STABLE_CYC + 3) tick();
        check("hold_pio", pio_in_port, 32'h5555_AAAA);
        bus_read(ADDR_CTRL, rd);
        check("hold_before_reset", rd, 32'h6);
        evt_pulse = 8'h01;
        tick();
        evt_pulse = '0;
        tick();
        check("irq_before_reset", 32'(irq), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_pio", pio_in_port, 32'd0);
        check("async_reset_rd", avs_readdata, 32'd0);
        check("async_reset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        bus_read(ADDR_CTRL, rd);
        check("post_reset_ctrl", rd, 32'h0);
        bus_read(ADDR_MASK, rd);
        check("post_reset_mask", rd, 32'h0);

        // ---- randomized sticky/mask/live against reference ----
        begin
            logic [31:0] sticky_m, mask_m, clr, wd, exp_rd;
            logic [EVT_W-1:0] ev;
            logic irq_exp;
            int op;
            logic [2:0] a;
            sticky_m = '0; mask_m = '0;
            s_init = status_async;
            repeat (SYNC_STAGES + 2) tick();
            for (int k = 0; k < RAND_CYC; k++) begin
                op = int'($urandom_range(0, 3));
                ev = ($urandom_range(0, 3) == 0) ? EVT_W'($urandom) : '0;
                hist[k] = $urandom;
                status_async = hist[k];
                evt_pulse = ev;
                clr = '0; wd = '0; exp_rd = '0; a = ADDR_LIVE;
                case (op)
                    1: begin
                        case ($urandom_range(0, 2))
                            0: a = ADDR_LIVE;
                            1: a = ADDR_STICKY;
                            default: a = ADDR_MASK;
                        endcase
                        exp_rd = (a == ADDR_LIVE) ? hist_at(k - SYNC_STAGES) :
                                 (a == ADDR_STICKY) ? sticky_m : mask_m;
                        avs_address = a; avs_read = 1'b1;
                    end
                    2: begin
                        clr = $urandom;
                        avs_address = ADDR_STICKY; avs_writedata = clr; avs_write = 1'b1;
                    end
                    3: begin
                        wd = $urandom;
                        avs_address = ADDR_MASK; avs_writedata = wd; avs_write = 1'b1;
                    end
                    default: ;
                endcase
                irq_exp = |(sticky_m & mask_m);
                tick();
                avs_read = 1'b0; avs_write = 1'b0; evt_pulse = '0;
                sticky_m = (sticky_m & ~clr) | 32'(ev);
                if (op == 3) mask_m = wd;
                check($sformatf("rand_irq[%0d]", k), 32'(irq), 32'(irq_exp));
                check($sformatf("rand_pio[%0d]", k), pio_in_port, hist_at(k - SYNC_STAGES));
                if (op == 1) check($sformatf("rand_read[%0d]", k), avs_readdata, exp_rd);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
